mem_bus_arbiter: RTL

//  Shares one single-port byte RAM between two requesters: M0 = cpu data port, M1 = debug/program loader.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_pick2.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-master RAM arbiter
// Purpose: FSM state encoding, master index constants and the legal RAM read
//          latency range used by mem_bus_arbiter and rr_pick2.
// Ports:   none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 4;
  // Wide enough to hold RAM_LAT_MAX-1.
  localparam int CNT_W = 2;

  function automatic bit ram_lat_in_range(input int lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick
// Purpose: chooses which of two requesters gets the next transaction.
//          A tie goes to the master that was not granted last, unless hold_i
//          lets the last master keep the bus while it is still requesting.
// Ports:   req0_i/req1_i  request lines of M0/M1
//          last_i         master granted most recently
//          hold_i         last master may keep the bus if it requests
//          grant_o        chosen master index (meaningful when valid_o)
//          valid_o        at least one request present
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic hold_i,
  output logic grant_o,
  output logic valid_o
);

  logic last_req;

  assign last_req = (last_i == M1) ? req1_i : req0_i;
  assign valid_o  = req0_i | req1_i;

  always_comb begin
    grant_o = M0;
    if (hold_i && last_req) begin
      grant_o = last_i;
    end else if (req0_i && req1_i) begin
      grant_o = ~last_i;
    end else if (req1_i) begin
      grant_o = M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one single-port byte RAM between two masters
// Purpose: round-robin arbitration per transaction between M0 (cpu data port)
//          and M1 (debug/program loader). Request fields are captured at
//          grant; reads wait a fixed RAM_LAT cycles; ack pulses in DONE.
//          Optional MEM_ARB_BURST_EN: the granted master may keep the bus for
//          up to MAX_BURST consecutive grants while it keeps requesting.
// Ports:   clk, rst                  clock, synchronous active-high reset
//          m0_req/we/addr/wdata      M0 request in; m0_ack/m0_rdata out
//          m1_req/we/addr/wdata      M1 request in; m1_ack/m1_rdata out
//          ram_re/ram_we             one-cycle RAM strobes
//          ram_addr/ram_wdata        registered RAM address and write data
//          ram_rdata                 RAM read data, RAM_LAT cycles after ram_re
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RAM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (!ram_lat_in_range(RAM_LAT)) begin : g_bad_ram_lat
    $error("mem_bus_arbiter: RAM_LAT must be within 1..4");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("mem_bus_arbiter: MAX_BURST must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              pick_grant, pick_valid, hold;

  rr_pick2 u_pick (
    .req0_i  (m0_req),
    .req1_i  (m1_req),
    .last_i  (last_q),
    .hold_i  (hold),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

`ifdef MEM_ARB_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  // Counts consecutive grants to last_q; zero right after reset so the
  // first arbitration is a plain round-robin tie-break.
  logic [BURST_W-1:0] burst_q, burst_d;

  assign hold = (burst_q != '0) && (burst_q < BURST_MAX);

  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE && pick_valid) begin
      if (burst_q != '0 && pick_grant == last_q) begin
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);
      end else begin
        burst_d = BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_d  = pick_grant;
          state_d = ISSUE;
          if (pick_grant == M1) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
        end
      end
      ISSUE: begin
        ram_we = we_q;
        ram_re = ~we_q;
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (last_q == M1) begin
            m1_rdata_d = ram_rdata;
          end else begin
            m0_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // last_q still names the master that owns this transaction.
        m0_ack  = (last_q == M0);
        m1_ack  = (last_q == M1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= M1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
